// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and default datapath width for the ALU pipeline.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_AND  = 3'b000;
  localparam opcode_t OP_OR   = 3'b001;
  localparam opcode_t OP_ADD  = 3'b010;
  localparam opcode_t OP_NOT  = 3'b011;
  localparam opcode_t OP_SUB  = 3'b100;
  localparam opcode_t OP_XOR  = 3'b101;
  localparam opcode_t OP_SLT  = 3'b110;
  localparam opcode_t OP_NAND = 3'b111;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath producing a result plus ADD carry / SUB borrow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  opcode_t          opp,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Widened by one bit so the top bit is the carry-out (ADD) or borrow (SUB).
  assign sum  = {1'b0, lhs} + {1'b0, rhs};
  assign diff = {1'b0, lhs} - {1'b0, rhs};

  // Opcode decode; carry is only meaningful for ADD and SUB and is zero otherwise.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (opp)
      OP_AND:  res = lhs & rhs;
      OP_OR:   res = lhs | rhs;
      OP_ADD:  begin res = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
      OP_NOT:  res = ~lhs;
      OP_SUB:  begin res = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
      OP_XOR:  res = lhs ^ rhs;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(lhs) < $signed(rhs))};
      OP_NAND: res = ~(lhs & rhs);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and zero-bubble
// result forwarding into the LHS operand. Optional result flags (out_zero,
// out_neg, out_carry) are built when the macro ALU_FLAGS_EN is defined.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_lhs,
  input  logic [WIDTH-1:0] in_rhs,
  input  opcode_t          in_opp,
  input  logic             in_fwd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res
`ifdef ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_lhs;
  logic [WIDTH-1:0] s1_rhs;
  opcode_t          s1_opp;
  logic             s2_valid;
  logic [WIDTH-1:0] last_res;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic [WIDTH-1:0] fwd_val;

  // Handshake: S2 frees when empty or drained; S1 may refill in the same cycle it advances.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = !s1_valid || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // The single ALU sits on S1 contents and feeds both the S2 register and the forward path.
  alu_core #(.WIDTH(WIDTH)) u_core (
    .lhs   (s1_lhs),
    .rhs   (s1_rhs),
    .opp   (s1_opp),
    .res   (core_res),
    .carry (core_carry)
  );

  // Most recently accepted result: still in S1 (compute live) or already retired to last_res.
  assign fwd_val = s1_valid ? core_res : last_res;

  // Stage S1 captures the effective operands on acceptance and empties when it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lhs   <= '0;
      s1_rhs   <= '0;
      s1_opp   <= OP_AND;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_lhs   <= in_fwd ? fwd_val : in_lhs;
      s1_rhs   <= in_rhs;
      s1_opp   <= in_opp;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage S2 registers the ALU result and keeps a copy for later forwarding; holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_res  <= '0;
      last_res <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      out_res  <= core_res;
      last_res <= core_res;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef ALU_FLAGS_EN
  // Flags travel with out_res and follow the same load/hold/reset behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      out_carry <= 1'b0;
    end else if (s1_adv) begin
      out_zero  <= (core_res == '0);
      out_neg   <= core_res[WIDTH-1];
      out_carry <= core_carry;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = core_carry;
`endif

endmodule
